ccc_reconfig_ctrl: RTL and testbench

Sequencer for a fabric clock-conditioning circuit (CCC/PLL) with an 8-bit APB dynamic-reconfiguration port. It holds the PLL in reset, writes a configuration image over the CCC APB port and optionally reads it back to verify it. It then releases the PLL, qualifies LOCK, and only then releases the downstream fabric reset. It sits between the system reset logic and the CCC instance, and supervises lock loss after start-up.

---
 rtl/ccc_reconfig_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_ccc_reconfig_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccc_reconfig_ctrl.sv
`default_nettype none
// ==========================================================================
// ccc_reconfig_ctrl : CCC/PLL APB reconfiguration sequencer with lock supervision
// Revision 1.0
// ==========================================================================
module ccc_reconfig_ctrl #(
  parameter int         NUM_REGS     = 8,
  parameter logic [5:0] BASE_ADDR    = 6'h00,
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter int         LOCK_STABLE  = 256,
  parameter int         VERIFY       = 1,
  parameter int         AUTO_START   = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET_N,
  input  logic                  start,
  input  logic [8*NUM_REGS-1:0] cfg_data,
  input  logic                  ccc_lock,
  output logic                  ccc_psel,
  output logic                  ccc_penable,
  output logic                  ccc_pwrite,
  output logic [5:0]            ccc_paddr,
  output logic [7:0]            ccc_pwdata,
  input  logic [7:0]            ccc_prdata,
  output logic                  pll_arst_n,
  output logic                  fabric_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [7:0]            relock_cnt
);

  localparam int CNT_W = 17;
  localparam int IDX_W = 7;

  typedef enum logic [3:0] {
    S_IDLE, S_PLLRST, S_WR_SETUP, S_WR_ACCESS, S_RD_SETUP,
    S_RD_ACCESS, S_WAIT_LOCK, S_STABLE, S_DONE, S_ERROR
  } state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [1:0]            err_code_nx;
  logic [7:0]            relock_nx;
  logic [8*NUM_REGS-1:0] shadow;
  logic                  load_shadow;
  logic                  auto_pend;
  logic                  lock_meta, lock_s;
  logic [7:0]            cur_byte;
  logic                  last_idx;
  logic                  accept;

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= ccc_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      err_code   <= 2'b00;
      relock_cnt <= 8'd0;
      shadow     <= '0;
      auto_pend  <= (AUTO_START != 0);
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      err_code   <= err_code_nx;
      relock_cnt <= relock_nx;
      auto_pend  <= 1'b0;
      if (load_shadow)
        shadow <= cfg_data;
    end
  end

  assign cur_byte = shadow[8*int'(idx) +: 8];
  assign last_idx = (idx == IDX_W'(NUM_REGS-1));
  // auto_pend only ever fires out of IDLE, on the first clock after reset
  assign accept   = ((state == S_IDLE) && (start || auto_pend)) ||
                    (start && ((state == S_DONE) || (state == S_ERROR)));

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    idx_nx       = idx;
    err_code_nx  = err_code;
    relock_nx    = relock_cnt;
    load_shadow  = 1'b0;
    ccc_psel     = 1'b0;
    ccc_penable  = 1'b0;
    ccc_pwrite   = 1'b0;
    ccc_paddr    = 6'd0;
    ccc_pwdata   = 8'd0;
    pll_arst_n   = 1'b0;
    fabric_rst_n = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;

    case (state)
      S_IDLE: busy = 1'b0;
      S_PLLRST: begin
        if (cnt == CNT_W'(RST_CYCLES-1)) begin
          state_nx = S_WR_SETUP;
          cnt_nx   = '0;
          idx_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_WR_SETUP: begin
        ccc_psel   = 1'b1;
        ccc_pwrite = 1'b1;
        ccc_paddr  = BASE_ADDR + idx[5:0];
        ccc_pwdata = cur_byte;
        state_nx   = S_WR_ACCESS;
      end
      S_WR_ACCESS: begin
        ccc_psel    = 1'b1;
        ccc_penable = 1'b1;
        ccc_pwrite  = 1'b1;
        ccc_paddr   = BASE_ADDR + idx[5:0];
        ccc_pwdata  = cur_byte;
        if (last_idx) begin
          idx_nx   = '0;
          state_nx = (VERIFY != 0) ? S_RD_SETUP : S_WAIT_LOCK;
        end else begin
          idx_nx   = idx + 1'b1;
          state_nx = S_WR_SETUP;
        end
      end
      S_RD_SETUP: begin
        ccc_psel  = 1'b1;
        ccc_paddr = BASE_ADDR + idx[5:0];
        state_nx  = S_RD_ACCESS;
      end
      S_RD_ACCESS: begin
        ccc_psel    = 1'b1;
        ccc_penable = 1'b1;
        ccc_paddr   = BASE_ADDR + idx[5:0];
        if (ccc_prdata != cur_byte) begin
          err_code_nx = 2'b10;
          state_nx    = S_ERROR;
        end else if (last_idx) begin
          state_nx = S_WAIT_LOCK;
        end else begin
          idx_nx   = idx + 1'b1;
          state_nx = S_RD_SETUP;
        end
      end
      S_WAIT_LOCK: begin
        pll_arst_n = 1'b1;
        if (lock_s) begin
          state_nx = S_STABLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT-1)) begin
          err_code_nx = 2'b01;
          state_nx    = S_ERROR;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_STABLE: begin
        pll_arst_n = 1'b1;
        if (!lock_s) begin
          state_nx = S_WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(LOCK_STABLE-1)) begin
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DONE: begin
        pll_arst_n   = 1'b1;
        fabric_rst_n = 1'b1;
        done         = 1'b1;
        busy         = 1'b0;
        if (!lock_s) begin
          if (relock_cnt != 8'hFF)
            relock_nx = relock_cnt + 8'd1;
          state_nx = S_WAIT_LOCK;
          cnt_nx   = '0;
        end
      end
      S_ERROR: begin
        err  = 1'b1;
        busy = 1'b0;
      end
      default: state_nx = S_IDLE;
    endcase

    // A restart overrides any lock-loss transition but keeps the relock count
    if (accept) begin
      state_nx    = S_PLLRST;
      cnt_nx      = '0;
      err_code_nx = 2'b00;
      load_shadow = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccc_reconfig_ctrl.sv
`default_nettype none
// tb_ccc_reconfig_ctrl : randomized bench with a transaction-level reference model
module tb_ccc_reconfig_ctrl;

  localparam int         NUM_REGS     = 4;
  localparam logic [5:0] BASE_ADDR    = 6'h10;
  localparam int         RST_CYCLES   = 4;
  localparam int         LOCK_TIMEOUT = 100;
  localparam int         LOCK_STABLE  = 8;
  localparam int         VERIFY       = 1;
  localparam int         AUTO_START   = 1;
  localparam int         REL_LAT      = 2 + LOCK_STABLE + 1;

  logic                  PCLK = 1'b0;
  logic                  PRESET_N = 1'b0;
  logic                  start = 1'b0;
  logic [8*NUM_REGS-1:0] cfg_data = '0;
  logic                  ccc_lock = 1'b0;
  logic                  ccc_psel, ccc_penable, ccc_pwrite;
  logic [5:0]            ccc_paddr;
  logic [7:0]            ccc_pwdata, ccc_prdata;
  logic                  pll_arst_n, fabric_rst_n, busy, done, err;
  logic [1:0]            err_code;
  logic [7:0]            relock_cnt;

  ccc_reconfig_ctrl #(
    .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR), .RST_CYCLES(RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE(LOCK_STABLE),
    .VERIFY(VERIFY), .AUTO_START(AUTO_START)
  ) dut (
    .PCLK(PCLK), .PRESET_N(PRESET_N), .start(start), .cfg_data(cfg_data),
    .ccc_lock(ccc_lock), .ccc_psel(ccc_psel), .ccc_penable(ccc_penable),
    .ccc_pwrite(ccc_pwrite), .ccc_paddr(ccc_paddr), .ccc_pwdata(ccc_pwdata),
    .ccc_prdata(ccc_prdata), .pll_arst_n(pll_arst_n), .fabric_rst_n(fabric_rst_n),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .relock_cnt(relock_cnt)
  );

  always #5 PCLK = ~PCLK;

  // CCC register file model: echoes writes, optional corrupt byte at 0x12
  logic [7:0] mem [64];
  logic       mm_en = 1'b0;
  int         cyc = 0;

  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (ccc_psel && ccc_penable && ccc_pwrite)
      mem[ccc_paddr] <= ccc_pwdata;
  end

  assign ccc_prdata = (mm_en && ccc_paddr == 6'h12) ? 8'hFF : mem[ccc_paddr];

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] data;
    int         cyc;
  } tx_t;

  tx_t  txq[$];
  int   pll_rises[$], fab_rises[$], busy_rises[$];
  logic pll_q = 1'b0, fab_q = 1'b0, busy_q = 1'b0;
  logic prev_sel = 1'b0, prev_en = 1'b0;
  logic [5:0] prev_addr = 6'd0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge PCLK) begin
    if (PRESET_N && ccc_psel && ccc_penable) begin
      txq.push_back('{ccc_pwrite, ccc_paddr, ccc_pwrite ? ccc_pwdata : ccc_prdata, cyc});
      check_val("apb_setup_phase", 32'({prev_sel, prev_en, prev_addr}), 32'({1'b1, 1'b0, ccc_paddr}));
    end
    if (pll_arst_n && !pll_q)    pll_rises.push_back(cyc);
    if (fabric_rst_n && !fab_q)  fab_rises.push_back(cyc);
    if (busy && !busy_q)         busy_rises.push_back(cyc);
    pll_q     = pll_arst_n;
    fab_q     = fabric_rst_n;
    busy_q    = busy;
    prev_sel  = ccc_psel;
    prev_en   = ccc_penable;
    prev_addr = ccc_paddr;
  end

  function automatic logic [31:0] outs();
    return {8'd0, ccc_psel, ccc_penable, ccc_pwrite, ccc_paddr, ccc_pwdata,
            pll_arst_n, fabric_rst_n, busy, done, err, err_code};
  endfunction

  function automatic logic sig_sel(input int which);
    case (which)
      0:       return pll_arst_n;
      1:       return fabric_rst_n;
      2:       return !fabric_rst_n;
      3:       return err;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int which, input int limit, input string tag, output int c);
    c = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge PCLK);
      if (sig_sel(which)) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check_val(tag, 32'(sig_sel(which)), 32'd1);
  endtask

  // Expected k-th APB transfer: NUM_REGS writes then read-back of the same image
  function automatic logic [14:0] exp_tx(input int k, input logic [31:0] img, input int mm_idx);
    int         i;
    logic [7:0] b;
    i = (k < NUM_REGS) ? k : k - NUM_REGS;
    b = img[8*i +: 8];
    if (k >= NUM_REGS && i == mm_idx) b = 8'hFF;
    return {(k < NUM_REGS), BASE_ADDR + 6'(i), b};
  endfunction

  task automatic check_tx(input int base, input logic [31:0] img, input int mm_idx);
    int n_exp, n_got;
    n_exp = NUM_REGS + ((mm_idx < 0) ? NUM_REGS : mm_idx + 1);
    n_got = txq.size() - base;
    check_val("apb_count", n_got, n_exp);
    for (int k = 0; k < n_exp && k < n_got; k++)
      check_val($sformatf("apb_tx%0d", k),
                32'({txq[base+k].wr, txq[base+k].addr, txq[base+k].data}),
                32'(exp_tx(k, img, mm_idx)));
  endtask

  function automatic logic [31:0] rand_img();
    logic [31:0] v;
    v = $urandom;
    if (v[23:16] == 8'hFF) v[23:16] = 8'h5A;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge PCLK);
    PRESET_N = 1'b0;
    ccc_lock = 1'b0;
    start    = 1'b0;
    repeat (3) @(negedge PCLK);
    check_val("rst_outs", outs(), 32'd0);
    check_val("rst_relock", 32'(relock_cnt), 32'd0);
    PRESET_N = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          p, c, l, f, r, nb, fb, pb, found;
    logic [31:0] img;

    // Nominal bring-up
    img = 32'hA1B2C3D4;
    cfg_data = img;
    do_reset();
    nb = txq.size();
    wait_until(0, 200, "nom_pll", p);
    repeat (10) @(negedge PCLK);
    ccc_lock = 1'b1;
    l = cyc;
    wait_until(1, 100, "nom_fab", c);
    check_val("nom_rel_lat", c - l, REL_LAT);
    check_val("nom_done_busy_err", 32'({done, busy, err}), 32'h4);
    check_tx(nb, img, -1);
    if (txq.size() > nb) check_val("nom_pll_after_reads", p - txq[$].cyc, 1);
    if (busy_rises.size() > 0)
      check_val("nom_seq_lat", p - busy_rises[$], RST_CYCLES + 2*NUM_REGS*(1+VERIFY));

    // Lock loss while released
    nb = txq.size();
    pb = pll_rises.size();
    @(negedge PCLK);
    ccc_lock = 1'b0;
    f = cyc;
    wait_until(2, 20, "loss_fab", c);
    check_val("loss_fab_lat", c - f, 3);
    check_val("loss_done", 32'(done), 32'd0);
    repeat (20 - (cyc - f)) @(negedge PCLK);
    ccc_lock = 1'b1;
    r = cyc;
    wait_until(1, 100, "relock_fab", c);
    check_val("relock_lat", c - r, REL_LAT);
    check_val("relock_cnt", 32'(relock_cnt), 32'd1);
    check_val("relock_no_apb", txq.size() - nb, 0);
    check_val("relock_pll_rises", pll_rises.size() - pb, 0);
    check_val("relock_pll_level", 32'(pll_arst_n), 32'd1);

    // Verify mismatch at 0x12
    img = rand_img();
    cfg_data = img;
    mm_en = 1'b1;
    do_reset();
    nb = txq.size();
    wait_until(3, 200, "mm_err", c);
    check_val("mm_state", 32'({err, err_code, pll_arst_n, fabric_rst_n, busy}), 32'({1'b1, 2'b10, 3'b000}));
    if (txq.size() > nb) check_val("mm_err_lat", c - txq[$].cyc, 1);
    repeat (5) @(negedge PCLK);
    check_tx(nb, img, 2);
    check_val("mm_hold", 32'({err, err_code}), 32'h6);
    mm_en = 1'b0;
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    check_val("mm_restart", 32'({err, err_code, busy}), 32'h1);

    // Lock timeout; image changed mid-sequence must not be picked up
    img = rand_img();
    cfg_data = img;
    fb = fab_rises.size();
    do_reset();
    nb = txq.size();
    repeat (2) @(negedge PCLK);
    cfg_data = ~img;
    wait_until(0, 200, "to_pll", p);
    wait_until(3, LOCK_TIMEOUT + 20, "to_err", c);
    check_val("to_lat", c - p, LOCK_TIMEOUT);
    check_val("to_code", 32'(err_code), 32'h1);
    check_val("to_fab_never", fab_rises.size() - fb, 0);
    check_tx(nb, img, -1);

    // One-cycle lock glitch during stability qualification
    cfg_data = rand_img();
    do_reset();
    wait_until(0, 200, "gl_pll", p);
    repeat ($urandom_range(2, 12)) @(negedge PCLK);
    ccc_lock = 1'b1;
    repeat (6) @(negedge PCLK);
    ccc_lock = 1'b0;
    @(negedge PCLK);
    ccc_lock = 1'b1;
    r = cyc;
    wait_until(1, 100, "gl_fab", c);
    check_val("gl_rel_lat", c - r, REL_LAT);

    // Reset asserted during WR_ACCESS of byte 2
    img = rand_img();
    cfg_data = img;
    do_reset();
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge PCLK);
      if (ccc_psel && ccc_penable && ccc_pwrite && ccc_paddr == BASE_ADDR + 6'd2) found = 1;
    end
    check_val("mw_found", found, 1);
    #2 PRESET_N = 1'b0;
    #1;
    check_val("mw_async_outs", outs(), 32'd0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET_N = 1'b1;
    nb = txq.size();
    wait_until(0, 200, "mw_pll", p);
    check_tx(nb, img, -1);
    ccc_lock = 1'b1;
    wait_until(1, 100, "mw_fab", c);
    check_val("mw_done", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
